// File: rtl/mas_acc_if.sv
// mas_acc_if
//   Handshake/bus bundle between a driver (master) and the modular-add
//   accumulator (slave).
//   start/q       : frame start pulse and signed modulus
//   in_valid/in_ready, in_dout, in_tcmp : sample stream from the MAS stage
//   out_valid/out_ready, out_sum, out_hits : frame result stream
//   busy, q_err   : status (frame in progress, rejected modulus)
interface mas_acc_if #(
  parameter int CNT_W = 4
);
  logic                    start;
  logic signed [4:0]       q;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [3:0]       in_dout;
  logic        [1:0]       in_tcmp;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [4:0]       out_sum;
  logic        [CNT_W-1:0] out_hits;
  logic                    busy;
  logic                    q_err;

  modport master (
    output start, q, in_valid, in_dout, in_tcmp, out_ready,
    input  in_ready, out_valid, out_sum, out_hits, busy, q_err
  );

  modport slave (
    input  start, q, in_valid, in_dout, in_tcmp, out_ready,
    output in_ready, out_valid, out_sum, out_hits, busy, q_err
  );
endinterface

// File: rtl/mas_mod_accumulator.sv
// mas_mod_accumulator
//   Accumulates FRAME_LEN signed residues from the MAS stage into a running
//   sum modulo q, counts samples whose threshold flag (tcmp[1]) is set, and
//   presents {sum, hits} on a valid/ready output.
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears all state and outputs
//   abort : (only with MAS_ACC_ABORT_EN) drops the frame in progress
//   bus   : mas_acc_if.slave -- start/q, sample stream, result stream, status
// Configuration macro
//   MAS_ACC_ABORT_EN : adds the abort input.
module mas_mod_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic     clk,
  input  logic     rst,
`ifdef MAS_ACC_ABORT_EN
  input  logic     abort,
`endif
  mas_acc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                  state, state_nxt;
  logic signed [4:0]       acc, q_reg, sum_out;
  logic        [CNT_W-1:0] cnt, hits, hits_out, hits_nxt;
  logic                    q_err_r;
  logic                    q_ok, go, accept, last, abort_hit;
  logic signed [5:0]       sum_raw;
  logic signed [4:0]       acc_nxt;

  // acc is 0..q-1 and the residue -8..7 with q in 8..15, so a single
  // add or subtract of q brings the sum back into 0..q-1.
  function automatic logic signed [4:0] mod_fold(input logic signed [5:0] s,
                                                 input logic signed [5:0] m);
    logic signed [5:0] r;
    if (s >= m)
      r = s - m;
    else if (s < 0)
      r = s + m;
    else
      r = s;
    return r[4:0];
  endfunction

  // q is 5-bit signed, so only the lower bound can be violated.
  assign q_ok     = (bus.q >= 5'sd8);
  assign go       = (state == IDLE) && bus.start && q_ok;
  assign accept   = (state == ACCUM) && bus.in_valid;
  assign last     = accept && (cnt == CNT_W'(FRAME_LEN - 1));
  assign sum_raw  = {acc[4], acc} + {{2{bus.in_dout[3]}}, bus.in_dout};
  assign acc_nxt  = mod_fold(sum_raw, {q_reg[4], q_reg});
  assign hits_nxt = hits + CNT_W'(bus.in_tcmp[1]);

`ifdef MAS_ACC_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; abort overrides any accept or handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = ACCUM;
      ACCUM:   if (last) state_nxt = EMIT;
      EMIT:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit)
      state_nxt = IDLE;
  end

  // Accumulator, counters and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      q_reg    <= '0;
      cnt      <= '0;
      hits     <= '0;
      sum_out  <= '0;
      hits_out <= '0;
      q_err_r  <= 1'b0;
    end else begin
      q_err_r <= (state == IDLE) && bus.start && !q_ok;
      if (abort_hit) begin
        acc  <= '0;
        cnt  <= '0;
        hits <= '0;
      end else if (go) begin
        q_reg <= bus.q;
        acc   <= '0;
        cnt   <= '0;
        hits  <= '0;
      end else if (accept) begin
        acc  <= acc_nxt;
        cnt  <= cnt + CNT_W'(1);
        hits <= hits_nxt;
        // Result registers hold through EMIT and the following IDLE.
        if (last) begin
          sum_out  <= acc_nxt;
          hits_out <= hits_nxt;
        end
      end
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == EMIT);
  assign bus.busy      = (state != IDLE);
  assign bus.q_err     = q_err_r;
  assign bus.out_sum   = sum_out;
  assign bus.out_hits  = hits_out;

endmodule

// File: tb/tb_mas_mod_accumulator.sv
// tb_mas_mod_accumulator
//   Directed and randomized frames for mas_mod_accumulator with FRAME_LEN=4.
//   Expected sums come from the arithmetic definition: the frame total of the
//   residues reduced into 0..q-1; expected hits are the count of set flags.
module tb_mas_mod_accumulator;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  logic clk;
  logic rst;
`ifdef MAS_ACC_ABORT_EN
  logic abort;
`endif

  mas_acc_if #(.CNT_W(CNT_W)) bus ();

  mas_mod_accumulator #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef MAS_ACC_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fd[4];
  int ft[4];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int qv);
    bus.start = 1'b1;
    bus.q     = qv[4:0];
    step();
    bus.start = 1'b0;
  endtask

  // Runs one full frame from fd/ft with `gap` idle cycles before each sample
  // and `hold` cycles of out_ready=0 in EMIT.
  task automatic run_frame(input string tag, input int qv, input int gap,
                           input int hold);
    int tot;
    int h;
    int exp_sum;
    tot = 0;
    h   = 0;
    do_start(qv);
    chk({tag, ".busy"}, bus.busy, 1);
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        bus.in_valid = 1'b0;
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_dout  = fd[i][3:0];
      bus.in_tcmp  = {ft[i][0], 1'($urandom)};
      tot += fd[i];
      h   += ft[i];
      step();
      bus.in_valid = 1'b0;
      if (i < 3) begin
        chk({tag, ".mid_out_valid"}, bus.out_valid, 0);
        chk({tag, ".mid_in_ready"}, bus.in_ready, 1);
      end else begin
        chk({tag, ".out_valid"}, bus.out_valid, 1);
      end
    end
    exp_sum = ((tot % qv) + qv) % qv;
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'($urandom);
      bus.in_dout  = 4'($urandom);
      chk({tag, ".hold_valid"}, bus.out_valid, 1);
      chk({tag, ".hold_in_ready"}, bus.in_ready, 0);
      chk({tag, ".hold_sum"}, $signed(bus.out_sum), exp_sum);
      step();
    end
    bus.in_valid = 1'b0;
    chk({tag, ".sum"}, $signed(bus.out_sum), exp_sum);
    chk({tag, ".hits"}, bus.out_hits, h);
    // A start coinciding with the completing handshake must be ignored.
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.q         = 5'sd10;
    step();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk({tag, ".done_valid"}, bus.out_valid, 0);
    chk({tag, ".done_busy"}, bus.busy, 0);
    chk({tag, ".kept_sum"}, $signed(bus.out_sum), exp_sum);
    chk({tag, ".kept_hits"}, bus.out_hits, h);
  endtask

  initial begin
    rst           = 1'b1;
`ifdef MAS_ACC_ABORT_EN
    abort         = 1'b0;
`endif
    bus.start     = 1'b0;
    bus.q         = '0;
    bus.in_valid  = 1'b0;
    bus.in_dout   = '0;
    bus.in_tcmp   = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.q_err", bus.q_err, 0);
    chk("rst.out_sum", $signed(bus.out_sum), 0);
    chk("rst.out_hits", bus.out_hits, 0);
    step();
    rst = 1'b0;
    step();

    fd = '{7, 7, 7, -8};
    ft = '{1, 1, 0, 0};
    run_frame("t1_q10", 10, 0, 0);

    fd = '{7, 7, 7, 7};
    ft = '{0, 1, 0, 1};
    run_frame("t2_q15", 15, 0, 1);

    fd = '{-8, -8, -8, -8};
    ft = '{1, 1, 1, 1};
    run_frame("t2_q8", 8, 0, 0);

    bus.start = 1'b1;
    bus.q     = 5'sd5;
    step();
    bus.start = 1'b0;
    chk("t3_q5.q_err", bus.q_err, 1);
    chk("t3_q5.busy", bus.busy, 0);
    chk("t3_q5.in_ready", bus.in_ready, 0);
    step();
    chk("t3_q5.q_err_drop", bus.q_err, 0);
    bus.start = 1'b1;
    bus.q     = -5'sd3;
    step();
    bus.start = 1'b0;
    chk("t3_qm3.q_err", bus.q_err, 1);
    chk("t3_qm3.in_ready", bus.in_ready, 0);
    step();
    chk("t3_qm3.q_err_drop", bus.q_err, 0);
    chk("t3_qm3.busy", bus.busy, 0);

    fd = '{3, -5, 6, 2};
    ft = '{1, 0, 1, 1};
    run_frame("t4_throttle", 11, 2, 3);

    do_start(10);
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_dout  = 4'sd3;
      bus.in_tcmp  = 2'b10;
      step();
    end
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5.rst_busy", bus.busy, 0);
    chk("t5.rst_in_ready", bus.in_ready, 0);
    chk("t5.rst_out_valid", bus.out_valid, 0);
    chk("t5.rst_sum", $signed(bus.out_sum), 0);
    chk("t5.rst_hits", bus.out_hits, 0);
    step();
    rst = 1'b0;
    step();
    fd = '{1, 1, 1, 1};
    ft = '{0, 0, 0, 0};
    run_frame("t5_after", 10, 0, 0);

`ifdef MAS_ACC_ABORT_EN
    do_start(12);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_dout  = 4'sd5;
      bus.in_tcmp  = 2'b10;
      if (i == 2) abort = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    abort        = 1'b0;
    chk("t6.abort_busy", bus.busy, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t6.abort_no_valid", bus.out_valid, 0);
      step();
    end
    fd = '{2, 2, 2, 2};
    ft = '{1, 0, 0, 0};
    run_frame("t6_after", 12, 0, 0);
`endif

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 4; i++) begin
        fd[i] = int'($urandom_range(0, 15)) - 8;
        ft[i] = int'($urandom_range(0, 1));
      end
      run_frame("rand", int'($urandom_range(8, 15)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
